// File: rtl/module_interfaz_spi_gen_pkg.sv
// Shared types for the SPI master: FSM state encoding, control register
// field positions and the packed control register image.
package module_interfaz_spi_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_STORE,
      ST_DONE
   } spi_state_e;

   // Control register bit positions
   localparam int CTRL_SEND      = 0;
   localparam int CTRL_ALL_ONES  = 1;
   localparam int CTRL_CPHA      = 2;
   localparam int CTRL_CPOL      = 3;
   localparam int CTRL_NTX_LSB   = 4;
   localparam int CTRL_NTX_MSB   = 12;
   localparam int CTRL_RXCNT_LSB = 16;
   localparam int CTRL_RXCNT_MSB = 25;
   // Highest host-writable control bit
   localparam int CTRL_WR_MSB    = 12;

   typedef struct packed {
      logic [9:0] rx_cnt;
      logic [8:0] n_tx;
      logic       cpol;
      logic       cpha;
      logic       all_ones;
      logic       send;
   } ctrl_t;

   // Place the control fields at their register positions; unused bits read 0.
   function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
      logic [31:0] w;
      w = '0;
      w[CTRL_SEND]                     = c.send;
      w[CTRL_ALL_ONES]                 = c.all_ones;
      w[CTRL_CPHA]                     = c.cpha;
      w[CTRL_CPOL]                     = c.cpol;
      w[CTRL_NTX_MSB:CTRL_NTX_LSB]     = c.n_tx;
      w[CTRL_RXCNT_MSB:CTRL_RXCNT_LSB] = c.rx_cnt;
      return w;
   endfunction

endpackage

// File: rtl/module_spi_clkgen.sv
// SCLK generator: divides clk_i by CLK_DIV into half-periods, flags the
// leading/trailing SCLK edges one cycle before they appear on sclk_o, and
// marks the end of the 2*W half-period shift window.
module module_spi_clkgen #(
   parameter int W       = 8,
   parameter int CLK_DIV = 10
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,      // SETUP or SHIFT: divider running
   input  logic shift_i,   // SHIFT: half-period counter running
   input  logic cpol_i,
   output logic sclk_o,
   output logic lead_o,
   output logic trail_o,
   output logic last_o
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HP_W  = $clog2(2 * W);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [HP_W-1:0]  HP_LAST = HP_W'(2 * W - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [HP_W-1:0]  hp_cnt_q, hp_cnt_d;
   logic             sclk_q, sclk_d;
   logic             tick;

   // Divider, edge strobes and SCLK level. The SETUP->SHIFT transition is the
   // first leading edge; the last half-period ends at idle level, so the
   // end of SHIFT produces no edge.
   always_comb begin
      tick      = en_i && (div_cnt_q == DIV_MAX);
      lead_o    = tick && (!shift_i || (hp_cnt_q[0] && (hp_cnt_q != HP_LAST)));
      trail_o   = tick && shift_i && !hp_cnt_q[0];
      last_o    = tick && shift_i && (hp_cnt_q == HP_LAST);
      div_cnt_d = (en_i && !tick) ? div_cnt_q + 1'b1 : '0;
      hp_cnt_d  = hp_cnt_q;
      if (!shift_i) begin
         hp_cnt_d = '0;
      end else if (tick) begin
         hp_cnt_d = hp_cnt_q + 1'b1;
      end
      sclk_d = sclk_q;
      if (lead_o || trail_o) begin
         sclk_d = ~sclk_q;
      end else if (!shift_i) begin
         sclk_d = cpol_i;
      end
   end

   // Divider state and SCLK register; SCLK drops to 0 immediately on reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_cnt_q <= '0;
         hp_cnt_q  <= '0;
         sclk_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         hp_cnt_q  <= hp_cnt_d;
         sclk_q    <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;

endmodule

// File: rtl/module_interfaz_spi_gen.sv
// SPI master with a host-visible control register and a DEPTH-entry data
// bank. A burst sends n_tx+1 words from the bank (or all ones), MSB first,
// and writes each received word back into the slot it came from.
module module_interfaz_spi_gen
   import module_interfaz_spi_gen_pkg::*;
#(
   parameter int W       = 8,
   parameter int DEPTH   = 8,
   parameter int CLK_DIV = 10
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     wr_i,
   input  logic                     reg_sel_i,
   input  logic [31:0]              entrada_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic                     bit_rx_i,
   output logic                     bit_tx_o,
   output logic                     sclk_o,
   output logic                     cs_n_o,
   output logic [31:0]              salida_o
);

   localparam int AW   = $clog2(DEPTH);
   localparam int BC_W = $clog2(W + 1);
   localparam logic [BC_W-1:0] BITS_ALL = BC_W'(W);

   logic [W-1:0]    data_q [DEPTH];

   spi_state_e      state_q, state_d;
   ctrl_t           ctrl_q, ctrl_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [8:0]      xfer_q, xfer_d;
   logic [W-1:0]    tx_sreg_q, tx_sreg_d;
   logic [W-1:0]    rx_sreg_q, rx_sreg_d;
   logic            bit_tx_q, bit_tx_d;
   logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;

   logic            lead, trail, last;
   logic            launch, sample, load;
   logic [W-1:0]    load_word;
   logic            host_we, store_we;
   logic            clk_en, clk_shift;
   logic            unused_entrada;

   // Control bits above the writable range are never stored.
   assign unused_entrada = ^entrada_i[31:CTRL_WR_MSB+1];

   module_spi_clkgen #(
      .W       (W),
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (clk_en),
      .shift_i (clk_shift),
      .cpol_i  (ctrl_q.cpol),
      .sclk_o  (sclk_o),
      .lead_o  (lead),
      .trail_o (trail),
      .last_o  (last)
   );

   // Decode state into chip select, clock generator enables and bank write strobes.
   always_comb begin
      clk_en    = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
      clk_shift = (state_q == ST_SHIFT);
      cs_n_o    = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_STORE));
      host_we   = wr_i && reg_sel_i;
      store_we  = (state_q == ST_STORE);
   end

   // Next-state logic, control register updates and word sequencing.
   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      idx_d   = idx_q;
      xfer_d  = xfer_q;
      load    = 1'b0;
      if (wr_i && !reg_sel_i && (state_q == ST_IDLE)) begin
         ctrl_d.send     = entrada_i[CTRL_SEND];
         ctrl_d.all_ones = entrada_i[CTRL_ALL_ONES];
         ctrl_d.cpha     = entrada_i[CTRL_CPHA];
         ctrl_d.cpol     = entrada_i[CTRL_CPOL];
         ctrl_d.n_tx     = entrada_i[CTRL_NTX_MSB:CTRL_NTX_LSB];
         ctrl_d.rx_cnt   = '0;
      end
      case (state_q)
         ST_IDLE: begin
            if (ctrl_q.send) begin
               state_d = ST_SETUP;
               idx_d   = '0;
               xfer_d  = '0;
               load    = 1'b1;
            end
         end
         ST_SETUP: begin
            if (lead) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last) begin
               state_d = ST_STORE;
            end
         end
         ST_STORE: begin
            ctrl_d.rx_cnt = ctrl_q.rx_cnt + 1'b1;
            idx_d         = idx_q + 1'b1;
            if (xfer_q < ctrl_q.n_tx) begin
               xfer_d  = xfer_q + 1'b1;
               state_d = ST_SETUP;
               load    = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ctrl_d.send = 1'b0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift datapath. With CPHA=0 the MSB is driven as SETUP starts and the
   // final trailing edge launches nothing, so MOSI holds the LSB to the end.
   // With CPHA=1 every bit, MSB included, is launched on a leading edge.
   always_comb begin
      load_word = ctrl_q.all_ones ? '1 : data_q[idx_d];
      launch    = ctrl_q.cpha ? lead : (trail && (bit_cnt_q != BITS_ALL));
      sample    = ctrl_q.cpha ? trail : lead;
      tx_sreg_d = tx_sreg_q;
      rx_sreg_d = rx_sreg_q;
      bit_tx_d  = bit_tx_q;
      bit_cnt_d = bit_cnt_q;
      if (load) begin
         bit_cnt_d = '0;
         if (ctrl_q.cpha) begin
            tx_sreg_d = load_word;
         end else begin
            bit_tx_d  = load_word[W-1];
            tx_sreg_d = load_word << 1;
         end
      end else begin
         if (launch) begin
            bit_tx_d  = tx_sreg_q[W-1];
            tx_sreg_d = tx_sreg_q << 1;
         end
         if (sample) begin
            rx_sreg_d = {rx_sreg_q[W-2:0], bit_rx_i};
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end
   end

   // Control and datapath registers; reset aborts any burst immediately.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         ctrl_q    <= '0;
         idx_q     <= '0;
         xfer_q    <= '0;
         tx_sreg_q <= '0;
         rx_sreg_q <= '0;
         bit_tx_q  <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         idx_q     <= idx_d;
         xfer_q    <= xfer_d;
         tx_sreg_q <= tx_sreg_d;
         rx_sreg_q <= rx_sreg_d;
         bit_tx_q  <= bit_tx_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Data bank (not reset). The STORE write comes last so it wins an index clash.
   always_ff @(posedge clk_i) begin
      if (host_we) begin
         data_q[addr_i] <= entrada_i[W-1:0];
      end
      if (store_we) begin
         data_q[idx_q] <= rx_sreg_q;
      end
   end

   // Host read mux.
   always_comb begin
      salida_o = ctrl_to_word(ctrl_q);
      if (reg_sel_i) begin
         salida_o = 32'(data_q[addr_i]);
      end
   end

   assign bit_tx_o = bit_tx_q;

endmodule

// File: tb/tb_module_interfaz_spi_gen.sv
// Directed + randomized bench for the SPI master, checked against a
// word-level model of the data bank and a serial-line monitor.
module tb_module_interfaz_spi_gen;

   localparam int W        = 8;
   localparam int DEPTH    = 8;
   localparam int CLK_DIV  = 2;
   localparam int WORD_CYC = CLK_DIV * (2 * W + 1) + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr;
   logic        reg_sel;
   logic [31:0] entrada;
   logic [2:0]  addr;
   logic        bit_rx;
   logic        bit_tx;
   logic        sclk;
   logic        cs_n;
   logic [31:0] salida;
   logic        loop_mode;
   logic        rx_val;

   always #5 clk = ~clk;

   assign bit_rx = loop_mode ? bit_tx : rx_val;

   module_interfaz_spi_gen #(
      .W       (W),
      .DEPTH   (DEPTH),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .wr_i      (wr),
      .reg_sel_i (reg_sel),
      .entrada_i (entrada),
      .addr_i    (addr),
      .bit_rx_i  (bit_rx),
      .bit_tx_o  (bit_tx),
      .sclk_o    (sclk),
      .cs_n_o    (cs_n),
      .salida_o  (salida)
   );

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] model_mem [DEPTH];
   logic [7:0] exp_q [$];

   // Serial-line monitor state
   logic       mon_cpol = 1'b0;
   logic       mon_cpha = 1'b0;
   logic       sclk_prev = 1'b0;
   logic       tx_prev = 1'b0;
   logic       cs_prev = 1'b1;
   int         edges = 0;
   int         cs_falls = 0;
   int         cs_low_cycles = 0;
   int         tx_low_seen = 0;
   int         bad_mosi = 0;
   int         mon_bits = 0;
   logic [7:0] mon_word = 8'h00;
   logic [7:0] mon_q [$];

   always @(negedge clk) begin
      logic leading;
      if (cs_n === 1'b0) begin
         cs_low_cycles++;
         if (bit_tx !== 1'b1) tx_low_seen++;
         if (sclk !== sclk_prev) begin
            edges++;
            leading = (sclk_prev == mon_cpol);
            if (leading != mon_cpha) begin
               mon_word = {mon_word[6:0], bit_tx};
               mon_bits++;
               if (mon_bits == 8) begin
                  mon_q.push_back(mon_word);
                  mon_bits = 0;
               end
            end
         end
         if (!cs_prev && mon_cpha && (bit_tx !== tx_prev) &&
             !((sclk_prev == mon_cpol) && (sclk != mon_cpol)))
            bad_mosi++;
      end
      if (cs_prev && (cs_n === 1'b0)) cs_falls++;
      sclk_prev = sclk;
      tx_prev   = bit_tx;
      cs_prev   = cs_n;
   end

   task automatic mon_clear();
      edges = 0; cs_falls = 0; cs_low_cycles = 0; tx_low_seen = 0;
      bad_mosi = 0; mon_bits = 0; mon_q.delete();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic host_wr(input logic sel, input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      wr = 1'b1; reg_sel = sel; addr = a; entrada = d;
      @(negedge clk);
      wr = 1'b0; reg_sel = 1'b0; addr = 3'd0; entrada = 32'd0;
   endtask

   task automatic host_rd(input logic sel, input logic [2:0] a, output logic [31:0] d);
      reg_sel = sel; addr = a;
      #1;
      d = salida;
      reg_sel = 1'b0; addr = 3'd0;
   endtask

   task automatic mem_wr(input int j, input logic [7:0] v);
      host_wr(1'b1, 3'(j), 32'(v));
      model_mem[j] = v;
   endtask

   task automatic check_bank(input string tag);
      logic [31:0] rd;
      for (int j = 0; j < DEPTH; j++) begin
         host_rd(1'b1, 3'(j), rd);
         check($sformatf("%s data[%0d]", tag, j), rd, 32'(model_mem[j]));
      end
   endtask

   // One burst: model the expected words, run it, then compare everything.
   task automatic run_burst(input int n, input logic ones, input logic cpha, input logic cpol,
                            input logic loop, input logic rv, input string tag);
      logic [31:0] cw;
      logic [31:0] rd;
      logic [7:0]  tx;
      logic [7:0]  rx;
      int          cyc;
      mon_cpha = cpha; mon_cpol = cpol; loop_mode = loop; rx_val = rv;
      exp_q.delete();
      for (int k = 0; k <= n; k++) begin
         tx = ones ? 8'hFF : model_mem[k % DEPTH];
         rx = loop ? tx : (rv ? 8'hFF : 8'h00);
         exp_q.push_back(tx);
         model_mem[k % DEPTH] = rx;
      end
      cw = (32'(n) << 4) | (32'(cpol) << 3) | (32'(cpha) << 2) | (32'(ones) << 1);
      host_wr(1'b0, 3'd0, cw);
      repeat (3) @(negedge clk);
      check({tag, " idle sclk"}, 32'(sclk), 32'(cpol));
      @(posedge clk); #1;
      mon_clear();
      host_wr(1'b0, 3'd0, cw | 32'h1);
      cyc = 0;
      host_rd(1'b0, 3'd0, rd);
      while (rd[0] && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         host_rd(1'b0, 3'd0, rd);
      end
      check({tag, " burst cycles"}, 32'(cyc), 32'((n + 1) * WORD_CYC + 2));
      check({tag, " control"}, rd, cw | (32'(n + 1) << 16));
      check_bank(tag);
      check({tag, " mosi words"}, 32'(mon_q.size()), 32'(n + 1));
      for (int k = 0; k <= n; k++)
         if (k < mon_q.size())
            check($sformatf("%s mosi word %0d", tag, k), 32'(mon_q[k]), 32'(exp_q[k]));
      check({tag, " sclk edges"}, 32'(edges), 32'(2 * W * (n + 1)));
      check({tag, " cs assertions"}, 32'(cs_falls), 32'd1);
      check({tag, " cs low cycles"}, 32'(cs_low_cycles), 32'(WORD_CYC * (n + 1)));
      if (cpha) check({tag, " mosi on leading edge"}, 32'(bad_mosi), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      int          cyc;
      rst_n = 1'b0; wr = 1'b0; reg_sel = 1'b0; entrada = 32'd0; addr = 3'd0;
      loop_mode = 1'b1; rx_val = 1'b0;
      repeat (3) @(negedge clk);
      check("reset cs_n", 32'(cs_n), 32'd1);
      check("reset sclk", 32'(sclk), 32'd0);
      check("reset mosi", 32'(bit_tx), 32'd0);
      rst_n = 1'b1;
      host_rd(1'b0, 3'd0, rd);
      check("reset control", rd, 32'd0);
      for (int j = 0; j < DEPTH; j++) mem_wr(j, 8'($urandom));

      // Loopback burst of three words, mode 0
      mem_wr(0, 8'h89); mem_wr(1, 8'h76); mem_wr(2, 8'h54);
      run_burst(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "loop3");

      // MISO stuck high, single word
      mem_wr(0, 8'h12);
      run_burst(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "miso1");

      // All-ones transmit, two words
      run_burst(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "ones");
      check("ones mosi high", 32'(tx_low_seen), 32'd0);

      // Mode 3 loopback
      mem_wr(0, 8'hA5);
      run_burst(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "mode3");

      // Randomized bursts
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < DEPTH; j++) mem_wr(j, 8'($urandom));
         run_burst(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), $sformatf("rand%0d", r));
      end

      // Index wrap: ten words over an eight-entry bank
      for (int j = 0; j < DEPTH; j++) mem_wr(j, 8'($urandom));
      run_burst(9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "wrap");

      // Reset in the middle of a shift
      for (int j = 0; j < DEPTH; j++) mem_wr(j, 8'($urandom));
      loop_mode = 1'b0; rx_val = 1'b0; mon_cpha = 1'b0; mon_cpol = 1'b0;
      host_wr(1'b0, 3'd0, 32'h30);
      host_wr(1'b0, 3'd0, 32'h31);
      cyc = 0;
      while (!(sclk === 1'b1 && cs_n === 1'b0) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("abort reached shift", 32'(sclk === 1'b1 && cs_n === 1'b0), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("abort cs_n", 32'(cs_n), 32'd1);
      check("abort sclk", 32'(sclk), 32'd0);
      check("abort mosi", 32'(bit_tx), 32'd0);
      host_rd(1'b0, 3'd0, rd);
      check("abort control", rd, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("abort cs_n idle", 32'(cs_n), 32'd1);
      check_bank("abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
